// File: rtl/ai_av_writer_if.sv
// ai_av_writer_if: bus bundle for the AI comparer write-side front end.
// Carries the Avalon-MM write port from the host and the byte stream
// (data_out/data_valid/data_ready) toward the compare engine.
interface ai_av_writer_if;
   logic        avs_s0_write;
   logic [3:0]  avs_s0_address;
   logic [31:0] avs_s0_writedata;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        data_ready;

   // Seen from the writer block: host writes and engine ready come in
   modport slave (
      input  avs_s0_write,
      input  avs_s0_address,
      input  avs_s0_writedata,
      input  data_ready,
      output data_out,
      output data_valid
   );

   // Seen from the host / compare engine side
   modport master (
      output avs_s0_write,
      output avs_s0_address,
      output avs_s0_writedata,
      output data_ready,
      input  data_out,
      input  data_valid
   );
endinterface

// File: rtl/ai_av_writer.sv
// ai_av_writer: Avalon-MM write-side front end of the AI comparer.
// Decodes host writes into configuration registers, a byte sample FIFO and
// run-control commands, then runs INIT -> RUN -> DONE streaming len bytes.
// Optional feature macro: AI_WR_OVF_STICKY_EN (sticky FIFO overflow flag).
module ai_av_writer #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ai_av_writer_if.slave        bus,
   output logic                 init,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          reg1,
   output logic [31:0]          reg2,
   output logic [31:0]          crc_seed,
   output logic [31:0]          len,
   output logic                 fifo_full,
   output logic                 ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [31:0]     sent_q, sent_d;
   logic [31:0]     len_q, len_d;
   logic [31:0]     reg1_q, reg1_d;
   logic [31:0]     reg2_q, reg2_d;
   logic [31:0]     seed_q, seed_d;

   logic            active_s;
   logic            run_s;
   logic            fifo_empty_s;
   logic            fifo_full_s;
   logic            ctl_wr;
   logic            start_req;
   logic            abort_req;
   logic            abort_hit;
   logic            push_req;
   logic            push_ok;
   logic            pop;
   logic            cfg_wr;

   // ---------------------------------------------------------------
   // Command decode
   // ---------------------------------------------------------------
   assign active_s     = (state_q == ST_INIT) || (state_q == ST_RUN);
   assign run_s        = (state_q == ST_RUN);
   assign fifo_empty_s = (count_q == CNT_ZERO);
   assign fifo_full_s  = (count_q == DEPTH_C);

   assign ctl_wr    = bus.avs_s0_write && (bus.avs_s0_address == 4'd1);
   assign start_req = ctl_wr && bus.avs_s0_writedata[0];
   assign abort_req = ctl_wr && bus.avs_s0_writedata[1];
   // Abort only acts while a run is in progress
   assign abort_hit = abort_req && active_s;

   assign push_req  = bus.avs_s0_write && (bus.avs_s0_address == 4'd0);
   // The transfer depends only on registered occupancy and the engine ready
   assign pop       = run_s && !fifo_empty_s && bus.data_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle;
   // an abort flushes everything including a same-cycle push
   assign push_ok   = push_req && (!fifo_full_s || pop) && !abort_hit;

   // Configuration registers are frozen while a run is in flight
   assign cfg_wr    = bus.avs_s0_write && !active_s;

   // Run sequencer next-state and sent-byte counter
   always_comb begin
      state_d = state_q;
      sent_d  = sent_q;
      case (state_q)
         ST_IDLE: begin
            if (start_req && !abort_req && (len_q != 32'd0)) begin
               state_d = ST_INIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_INIT: begin
            if (abort_hit) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
               sent_d  = 32'd0;
            end
         end
         ST_RUN: begin
            if (abort_hit) begin
               state_d = ST_IDLE;
            end else if (pop) begin
               sent_d = sent_q + 32'd1;
               if ((sent_q + 32'd1) == len_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sent_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         sent_q  <= sent_d;
      end
   end

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (abort_hit) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         count_d  = CNT_ZERO;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO pointer and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage; cleared on reset so no stale byte can ever leak out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= bus.avs_s0_writedata[7:0];
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   // Configuration register next-state from the address map
   always_comb begin
      len_d  = len_q;
      reg1_d = reg1_q;
      reg2_d = reg2_q;
      seed_d = seed_q;
      if (cfg_wr) begin
         case (bus.avs_s0_address)
            4'd2:    len_d  = bus.avs_s0_writedata;
            4'd12:   reg1_d = bus.avs_s0_writedata;
            4'd13:   reg2_d = bus.avs_s0_writedata;
            4'd15:   seed_d = bus.avs_s0_writedata;
            default: len_d  = len_q;
         endcase
      end else begin
         len_d = len_q;
      end
   end

   // Configuration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q  <= 32'd0;
         reg1_q <= 32'd0;
         reg2_q <= 32'd0;
         seed_q <= 32'd0;
      end else begin
         len_q  <= len_d;
         reg1_q <= reg1_d;
         reg2_q <= reg2_d;
         seed_q <= seed_d;
      end
   end

`ifdef AI_WR_OVF_STICKY_EN
   logic ovf_q, ovf_d;
   logic clr_req;
   logic push_drop;

   assign clr_req   = ctl_wr && bus.avs_s0_writedata[2];
   assign push_drop = push_req && fifo_full_s && !pop && !abort_hit;

   // Sticky overflow: a drop outranks a same-cycle clear
   always_comb begin
      ovf_d = ovf_q;
      if (push_drop) begin
         ovf_d = 1'b1;
      end else if (clr_req) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Overflow flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Outputs: all derived from registered state only
   // ---------------------------------------------------------------
   assign init           = (state_q == ST_INIT);
   assign busy           = active_s;
   assign done           = (state_q == ST_DONE);
   assign reg1           = reg1_q;
   assign reg2           = reg2_q;
   assign crc_seed       = seed_q;
   assign len            = len_q;
   assign fifo_full      = fifo_full_s;
   assign bus.data_valid = run_s && !fifo_empty_s;
   assign bus.data_out   = fifo_empty_s ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ai_av_writer.sv
// tb_ai_av_writer: directed bench for ai_av_writer with a queue-based
// reference model compared on every falling edge, plus literal spot checks.
module tb_ai_av_writer;
   localparam int DEPTH = 8;
   localparam int M_IDLE = 0;
   localparam int M_INIT = 1;
   localparam int M_RUN  = 2;
   localparam int M_DONE = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        init, busy, done, fifo_full, ovf;
   logic [31:0] reg1, reg2, crc_seed, len;

   ai_av_writer_if bus_if ();

   ai_av_writer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .init      (init),
      .busy      (busy),
      .done      (done),
      .reg1      (reg1),
      .reg2      (reg2),
      .crc_seed  (crc_seed),
      .len       (len),
      .fifo_full (fifo_full),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_ph   = M_IDLE;
   logic [7:0]  m_q[$];
   logic [31:0] m_len  = 32'd0;
   logic [31:0] m_reg1 = 32'd0;
   logic [31:0] m_reg2 = 32'd0;
   logic [31:0] m_seed = 32'd0;
   logic [31:0] m_sent = 32'd0;
   logic        m_ovf  = 1'b0;

   initial begin : model
      bit w, ctl, st, ab, cl, act, xfer, push, drop;
      logic [3:0]  a;
      logic [31:0] d;
      int sz;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_ph = M_IDLE; m_q.delete();
            m_len = 32'd0; m_reg1 = 32'd0; m_reg2 = 32'd0; m_seed = 32'd0;
            m_sent = 32'd0; m_ovf = 1'b0;
         end else begin
            w    = bus_if.avs_s0_write;
            a    = bus_if.avs_s0_address;
            d    = bus_if.avs_s0_writedata;
            ctl  = w && (a == 4'd1);
            st   = ctl && d[0];
            ab   = ctl && d[1];
            cl   = ctl && d[2];
            act  = (m_ph == M_INIT) || (m_ph == M_RUN);
            xfer = (m_ph == M_RUN) && (m_q.size() != 0) && (bus_if.data_ready === 1'b1);
            push = w && (a == 4'd0);
            drop = 1'b0;
            if (ab && act) begin
               m_q.delete();
               m_ph = M_IDLE;
            end else begin
               sz = m_q.size();
               if (xfer) begin
                  void'(m_q.pop_front());
                  m_sent = m_sent + 32'd1;
               end
               if (push) begin
                  if (sz < DEPTH || xfer) m_q.push_back(d[7:0]);
                  else drop = 1'b1;
               end
               case (m_ph)
                  M_IDLE:  if (st && !ab && m_len != 32'd0) m_ph = M_INIT;
                  M_INIT:  begin m_ph = M_RUN; m_sent = 32'd0; end
                  M_RUN:   if (xfer && m_sent == m_len) m_ph = M_DONE;
                  default: m_ph = M_IDLE;
               endcase
            end
            if (w && !act) begin
               if (a == 4'd2)  m_len  = d;
               if (a == 4'd12) m_reg1 = d;
               if (a == 4'd13) m_reg2 = d;
               if (a == 4'd15) m_seed = d;
            end
`ifdef AI_WR_OVF_STICKY_EN
            if (drop) m_ovf = 1'b1;
            else if (cl) m_ovf = 1'b0;
`else
            if (drop || cl) m_ovf = 1'b0;
`endif
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      logic [7:0] exp_do;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_do = (m_q.size() != 0) ? m_q[0] : 8'h00;
            chk("m_init", {31'd0, init}, {31'd0, m_ph == M_INIT});
            chk("m_busy", {31'd0, busy}, {31'd0, (m_ph == M_INIT) || (m_ph == M_RUN)});
            chk("m_done", {31'd0, done}, {31'd0, m_ph == M_DONE});
            chk("m_valid", {31'd0, bus_if.data_valid}, {31'd0, (m_ph == M_RUN) && (m_q.size() != 0)});
            chk("m_data_out", {24'd0, bus_if.data_out}, {24'd0, exp_do});
            chk("m_full", {31'd0, fifo_full}, {31'd0, m_q.size() == DEPTH});
            chk("m_ovf", {31'd0, ovf}, {31'd0, m_ovf});
            chk("m_len", len, m_len);
            chk("m_reg1", reg1, m_reg1);
            chk("m_reg2", reg2, m_reg2);
            chk("m_seed", crc_seed, m_seed);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus_if.avs_s0_write     = 1'b1;
      bus_if.avs_s0_address   = a;
      bus_if.avs_s0_writedata = d;
      @(negedge clk);
      bus_if.avs_s0_write     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin : stim
      logic [7:0] eb;
      logic [7:0] sim_exp [8];
      bus_if.avs_s0_write     = 1'b0;
      bus_if.avs_s0_address   = 4'd0;
      bus_if.avs_s0_writedata = 32'd0;
      bus_if.data_ready       = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);

      // Reset / configuration
      wr(4'd12, 32'h11223344);
      wr(4'd13, 32'hA5A5A5A5);
      wr(4'd15, 32'hFFFFFFFF);
      chk("cfg_reg1", reg1, 32'h11223344);
      chk("cfg_reg2", reg2, 32'hA5A5A5A5);
      chk("cfg_seed", crc_seed, 32'hFFFFFFFF);
      wr(4'd2, 32'd3);
      wr(4'd0, 32'h77);
      chk("prefill_head", {24'd0, bus_if.data_out}, 32'h77);
      #2 rst = 1'b1;
      #1;
      chk("arst_regs", reg1 | reg2 | crc_seed | len, 32'd0);
      chk("arst_flags", {21'd0, init, busy, done, bus_if.data_valid, fifo_full, ovf, bus_if.data_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Basic run
      for (int i = 0; i < 4; i++) wr(4'd0, 32'h01 + i);
      wr(4'd2, 32'd4);
      bus_if.data_ready = 1'b1;
      wr(4'd1, 32'h1);
      chk("basic_init", {31'd0, init}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("basic_valid", {31'd0, bus_if.data_valid}, 32'd1);
         chk("basic_byte", {24'd0, bus_if.data_out}, 32'h01 + i);
      end
      @(negedge clk);
      chk("basic_done", {30'd0, done, busy}, 32'd2);
      @(negedge clk);
      chk("basic_after", {30'd0, done, busy}, 32'd0);

      // Backpressure with ready 1,0,1,0,...
      for (int i = 0; i < 4; i++) wr(4'd0, 32'hA1 + i);
      bus_if.data_ready = 1'b0;
      wr(4'd1, 32'h1);
      chk("bp_init", {31'd0, init}, 32'd1);
      @(negedge clk);
      for (int k = 0; k < 7; k++) begin
         eb = 8'hA1 + 8'((k + 1) / 2);
         chk("bp_byte", {24'd0, bus_if.data_out}, {24'd0, eb});
         chk("bp_nodone", {31'd0, done}, 32'd0);
         bus_if.data_ready = (k % 2 == 0) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      chk("bp_done", {31'd0, done}, 32'd1);
      bus_if.data_ready = 1'b1;
      idle(1);

      // Overflow: nine pushes into an idle depth-8 FIFO
      for (int i = 0; i < 9; i++) wr(4'd0, 32'h10 + i);
      chk("ovf_full", {31'd0, fifo_full}, 32'd1);
`ifdef AI_WR_OVF_STICKY_EN
      chk("ovf_set", {31'd0, ovf}, 32'd1);
`else
      chk("ovf_off", {31'd0, ovf}, 32'd0);
`endif
      chk("ovf_head", {24'd0, bus_if.data_out}, 32'h10);
      wr(4'd1, 32'h4);
      chk("ovf_clr", {31'd0, ovf}, 32'd0);
      wr(4'd2, 32'd8);
      wr(4'd1, 32'h1);
      idle(12);
      chk("ovf_drained", {30'd0, fifo_full, busy}, 32'd0);
      chk("ovf_empty_out", {24'd0, bus_if.data_out}, 32'h00);

      // Abort mid-run, config write during INIT ignored
      for (int i = 0; i < 3; i++) wr(4'd0, 32'h31 + i);
      wr(4'd2, 32'd6);
      wr(4'd1, 32'h1);
      chk("ab_init", {31'd0, init}, 32'd1);
      wr(4'd12, 32'hDEADBEEF);
      idle(2);
      chk("ab_reg1_frozen", reg1, 32'd0);
      chk("ab_head3", {24'd0, bus_if.data_out}, 32'h33);
      bus_if.data_ready = 1'b0;
      wr(4'd1, 32'h2);
      chk("ab_idle", {29'd0, busy, bus_if.data_valid, done}, 32'd0);
      chk("ab_flushed", {24'd0, bus_if.data_out}, 32'h00);
      idle(3);
      wr(4'd2, 32'd0);
      wr(4'd1, 32'h1);
      chk("len0_noinit", {30'd0, init, busy}, 32'd0);

      // Simultaneous push and pop on a full FIFO
      for (int i = 0; i < 8; i++) wr(4'd0, 32'h41 + i);
      wr(4'd2, 32'd9);
      wr(4'd1, 32'h1);
      chk("sim_init", {31'd0, init}, 32'd1);
      @(negedge clk);
      chk("sim_full", {31'd0, fifo_full}, 32'd1);
      chk("sim_head", {24'd0, bus_if.data_out}, 32'h41);
      bus_if.data_ready = 1'b1;
      wr(4'd0, 32'hEE);
      chk("sim_still_full", {31'd0, fifo_full}, 32'd1);
      chk("sim_ovf", {31'd0, ovf}, 32'd0);
      for (int k = 0; k < 8; k++) sim_exp[k] = (k < 7) ? (8'h42 + 8'(k)) : 8'hEE;
      for (int k = 0; k < 8; k++) begin
         chk("sim_byte", {24'd0, bus_if.data_out}, {24'd0, sim_exp[k]});
         @(negedge clk);
      end
      chk("sim_done", {31'd0, done}, 32'd1);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ai_av_writer.md
# ai_av_writer

Avalon-MM write-side front end of the AI comparer, paired with the comparer's register read path. It decodes host writes into comparer configuration registers, a byte sample FIFO and run-control commands. A run sequencer pulses `init`, then streams exactly `len` buffered sample bytes to the compare engine over a valid/ready handshake and pulses `done`.

## Interface
- `FIFO_DEPTH`, 8: sample FIFO depth in bytes; power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `avs_s0_write` in 1: Avalon write strobe; no wait states, always accepted.
- `avs_s0_address` in 4: word address.
- `avs_s0_writedata` in 32: write data.
- `init` out 1: one-cycle run-start pulse to the comparer.
- `busy` out 1: high in INIT and RUN.
- `done` out 1: one-cycle pulse after the last byte of a run is transferred.
- `reg1`, `reg2` out 32: comparer parameter registers.
- `crc_seed` out 32: CRC seed register.
- `len` out 32: run length in bytes.
- `data_out` out 8: FIFO head byte.
- `data_valid` out 1: `data_out` valid.
- `data_ready` in 1: compare engine accepts the byte.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `ovf` out 1: overflow flag; behaviour set under Configuration.

## Operation
- Address map. Unlisted addresses are ignored.
  - 0: push `writedata[7:0]` into the FIFO.
  - 1: control. bit0 = start, bit1 = abort, bit2 = clear `ovf`.
  - 2: `len`.
  - 12: `reg1`.
  - 13: `reg2`.
  - 15: `crc_seed`.
- Writes to addresses 2, 12, 13 and 15 are ignored while `busy`=1.
- FIFO pushes are allowed in any state, so the host may prefill before start.
- Push when full is dropped, except when a pop occurs in the same cycle. Then the push is accepted and occupancy stays at `FIFO_DEPTH`.
- Push into an empty FIFO: byte becomes visible (`data_valid`) the next cycle, never the same cycle.
- FSM states: IDLE, INIT, RUN, DONE.
  - IDLE → INIT: start=1 and `len`≠0. Start with `len`=0 is ignored.
  - INIT → RUN: after one cycle, with `init`=1 during INIT. The sent counter clears to 0.
  - RUN: `data_valid` = FIFO not empty. A transfer occurs when `data_valid`∧`data_ready`; it pops the head and increments the 32-bit sent counter.
  - RUN → DONE: on the transfer that brings the sent counter to `len`. Leftover FIFO bytes are kept.
  - DONE → IDLE: after one cycle, with `done`=1 during DONE.
  - Start while not IDLE is ignored.
- Abort in INIT or RUN → IDLE next cycle. The FIFO is flushed, no `done` pulse, and any push in that same cycle is discarded. Abort in IDLE or DONE has no effect.
- If one control write sets both start and abort, abort wins.
- `data_valid`=0 in every state other than RUN.

## Timing
- Every register write takes effect on the clock edge that samples it; the new value is visible the following cycle.
- Latencies:
  - Start write in cycle N → `init` high in N+1 → first possible transfer in N+2.
  - Last transfer in cycle M → `done` high in M+1 → `busy`=0 from M+1.
- `data_out` and `data_valid` are driven from registered FIFO pointers and occupancy only. There is no combinational path from `data_ready` to either.
- Reset, whether idle or mid-run:
  - state IDLE, FIFO empty, counters and pointers 0;
  - `reg1`, `reg2`, `crc_seed`, `len` = 0;
  - all outputs 0.
  - No `done` pulse is produced.

## Configuration
- `AI_WR_OVF_STICKY_EN` defined:
  - A dropped push sets `ovf`=1 the cycle after.
  - `ovf` stays set until a control write with bit2=1 or reset.
  - If a drop and a clear happen in the same cycle, the set wins.
- Not defined:
  - `ovf` is tied to 0.
  - Dropped pushes are discarded silently.
  - Control bit2 is ignored.

## Test plan
- Reset/config: write 12←0x11223344, 13←0xA5A5A5A5, 15←0xFFFFFFFF → registers read back on the outputs the next cycle. Assert `rst` asynchronously → all outputs 0 immediately.
- Basic run: push 0x01..0x04, write 2←4, write 1←0x1 with `data_ready`=1 → `init` one cycle later. Next four cycles: bytes 0x01..0x04 with `data_valid`=1. Then `done` one cycle, then `busy`=0.
- Backpressure: as above with `data_ready` toggling 1,0,1,0 → byte order is preserved and each byte is held stable while `data_ready`=0. `done` follows only after the 4th transfer.
- Overflow (macro on): with `FIFO_DEPTH`=8 and idle, push 9 bytes → `fifo_full`=1, `ovf`=1, 9th byte absent. Write 1←0x4 → `ovf`=0. With the macro off → `ovf` stays 0.
- Abort mid-run: `len`=6, 3 bytes pushed and 2 transferred, then write 1←0x2 → IDLE next cycle, FIFO empty, no `done`. A later start with `len`=0 → `init` is not asserted.
- Simultaneous full push/pop in RUN: FIFO full, push 0xEE in the same cycle as a transfer → occupancy stays 8, 0xEE is delivered last, `ovf` stays 0.
